// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Used by imem_loader and word_packer.
package imem_loader_pkg;

    localparam int IMEM_DEPTH_DEF = 256;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CSUM,
        END,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/word_packer.sv
// Packs accepted stream bytes into 32-bit words.
// Raises word_ready for one cycle after each fourth byte.
module word_packer
    import imem_loader_pkg::*;
#(
    parameter int BIG_ENDIAN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              take,
    input  logic [7:0]        data,
    output logic [WORD_W-1:0] word,
    output logic              word_ready
);

    logic [1:0]        cnt;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] shreg_next;

    // Big endian shifts bytes in from the bottom so the first lands on top;
    // little endian shifts in from the top so the first lands in [7:0].
    always_comb begin
        shreg_next = shreg;
        if (BIG_ENDIAN != 0) begin
            shreg_next = {shreg[WORD_W-9:0], data};
        end else begin
            shreg_next = {data, shreg[WORD_W-1:8]};
        end
    end

    // Byte counter, shift register and the latched word with its strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= 2'd0;
            shreg      <= '0;
            word       <= '0;
            word_ready <= 1'b0;
        end else begin
            word_ready <= 1'b0;
            if (clear) begin
                cnt <= 2'd0;
            end else if (take) begin
                shreg <= shreg_next;
                cnt   <= cnt + 2'd1;
                if (cnt == 2'd3) begin
                    word       <= shreg_next;
                    word_ready <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Length-prefixed byte stream writer for the instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH      = IMEM_DEPTH_DEF,
    parameter int BIG_ENDIAN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_waddr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err,
    output logic [8:0]  words_loaded
);

    localparam logic [15:0] DEPTH_L = 16'(DEPTH);
    localparam logic [8:0]  WL_MAX  = 9'(DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t TAIL     = CSUM;
    localparam logic   TAIL_RDY = 1'b1;
`else
    localparam state_t TAIL     = END;
    localparam logic   TAIL_RDY = 1'b0;
`endif

    state_t            state;
    logic [7:0]        len_hi;
    logic [17:0]       rem;
    logic [15:0]       len;
    logic              take;
    logic              go;
    logic              word_ready;
    logic [WORD_W-1:0] word;

    assign take = byte_valid & byte_ready;
    assign len  = {len_hi, byte_data};
    assign go   = start & ((state == IDLE) | (state == DONE) | (state == ERR));

    // The word counter doubles as the write index: it only saturates
    // once DEPTH words are written, after which no write can follow.
    assign imem_we    = word_ready;
    assign imem_wdata = word;
    assign imem_waddr = {21'd0, words_loaded, 2'b00};

    word_packer #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (go),
        .take       (take & (state == DATA)),
        .data       (byte_data),
        .word       (word),
        .word_ready (word_ready)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    // Running XOR over every data byte of the current load.
    always_ff @(posedge clk) begin
        if (reset) begin
            csum <= 8'd0;
        end else if (go) begin
            csum <= 8'd0;
        end else if (take && state == DATA) begin
            csum <= csum ^ byte_data;
        end
    end
`endif

    // Load sequencing with registered handshake, hold and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            byte_ready   <= 1'b0;
            cpu_hold     <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= 9'd0;
            len_hi       <= 8'd0;
            rem          <= 18'd0;
        end else begin
            if (imem_we && words_loaded != WL_MAX) begin
                words_loaded <= words_loaded + 9'd1;
            end
            unique case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state        <= LEN_HI;
                        byte_ready   <= 1'b1;
                        cpu_hold     <= 1'b1;
                        load_done    <= 1'b0;
                        load_err     <= 1'b0;
                        words_loaded <= 9'd0;
                    end
                end
                LEN_HI: begin
                    if (take) begin
                        len_hi <= byte_data;
                        state  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (take) begin
                        if (len > DEPTH_L) begin
                            state      <= ERR;
                            byte_ready <= 1'b0;
                            load_err   <= 1'b1;
                        end else if (len == 16'd0) begin
                            state      <= TAIL;
                            byte_ready <= TAIL_RDY;
                        end else begin
                            state <= DATA;
                            rem   <= {len, 2'b00};
                        end
                    end
                end
                DATA: begin
                    if (take) begin
                        rem <= rem - 18'd1;
                        if (rem == 18'd1) begin
                            state      <= TAIL;
                            byte_ready <= TAIL_RDY;
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (take) begin
                        byte_ready <= 1'b0;
                        if (byte_data == csum) begin
                            state <= END;
                        end else begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end
                    end
                end
`endif
                END: begin
                    state     <= DONE;
                    load_done <= 1'b1;
                    cpu_hold  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    byte_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader, big and little endian side by side.
// Expected writes come from the stream bytes; a monitor checks them.
module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit LAT = 1'b0;
`else
    localparam bit LAT = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;

    logic        b_ready, b_we, b_hold, b_done, b_err;
    logic [31:0] b_waddr, b_wdata;
    logic [8:0]  b_wl;
    logic        l_ready, l_we, l_hold, l_done, l_err;
    logic [31:0] l_waddr, l_wdata;
    logic [8:0]  l_wl;

    imem_loader #(.DEPTH(256), .BIG_ENDIAN(1)) dut_be (
        .clk(clk), .reset(reset), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(b_ready), .imem_we(b_we),
        .imem_waddr(b_waddr), .imem_wdata(b_wdata),
        .cpu_hold(b_hold), .load_done(b_done),
        .load_err(b_err), .words_loaded(b_wl)
    );

    imem_loader #(.DEPTH(256), .BIG_ENDIAN(0)) dut_le (
        .clk(clk), .reset(reset), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(l_ready), .imem_we(l_we),
        .imem_waddr(l_waddr), .imem_wdata(l_wdata),
        .cpu_hold(l_hold), .load_done(l_done),
        .load_err(l_err), .words_loaded(l_wl)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int last_we_cyc = 0;
    logic [7:0] last_csum;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] be;
        logic [31:0] le;
        int          hs;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    wr_t none = '{32'd0, 32'd0, 32'd0, 0};

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected word.
    always @(negedge clk) begin
        if (b_we || l_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_we: write addr 0x%0h data 0x%0h, required no write",
                         b_waddr, b_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("we_be", {31'd0, b_we}, 32'd1);
                chk("we_le", {31'd0, l_we}, 32'd1);
                chk("waddr_be", b_waddr, mon_e.addr);
                chk("waddr_le", l_waddr, mon_e.addr);
                chk("wdata_be", b_wdata, mon_e.be);
                chk("wdata_le", l_wdata, mon_e.le);
                chk("we_latency", cyc, mon_e.hs + 1);
            end
            last_we_cyc = cyc;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit jit,
                             input bit pstart, input bit push, input wr_t e);
        int n;
        wr_t x;
        if (jit) begin
            repeat ($urandom_range(0, 2)) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        byte_valid = 1'b1;
        byte_data  = b;
        start      = pstart;
        n = 0;
        while (!b_ready && n < 20) begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        if (!b_ready) begin
            checks++;
            errors++;
            $display("FAIL byte_ready_timeout: byte_ready=0 for %0d cycles, required 1", n);
            byte_valid = 1'b0;
            start      = 1'b0;
            return;
        end
        if (push) begin
            x    = e;
            x.hs = cyc;
            exp_q.push_back(x);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic begin_load(input logic [15:0] len);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("hold_on_start", {31'd0, b_hold}, 32'd1);
        chk("ready_on_start", {31'd0, b_ready}, 32'd1);
        chk("flags_cleared", {30'd0, b_done, b_err}, 32'd0);
        chk("wl_cleared", {23'd0, b_wl}, 32'd0);
        send_byte(len[15:8], 1'b0, 1'b0, 1'b0, none);
        send_byte(len[7:0], 1'b0, 1'b0, 1'b0, none);
    endtask

    task automatic send_data(input logic [7:0] d[$], input int n,
                             input bit jit, input int start_idx);
        wr_t e;
        for (int k = 0; k < n; k++) begin
            e = none;
            if (k % 4 == 3) begin
                e.addr = 32'((k / 4) * 4);
                e.be   = {d[k-3], d[k-2], d[k-1], d[k]};
                e.le   = {d[k], d[k-1], d[k-2], d[k-3]};
            end
            send_byte(d[k], jit, k == start_idx, k % 4 == 3, e);
        end
    endtask

    task automatic send_tail(input logic [7:0] d[$], input int n, input bit good);
        logic [7:0] x;
        x = 8'd0;
        for (int k = 0; k < n; k++) x = x ^ d[k];
        last_csum = good ? x : (x ^ 8'h01);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(last_csum, 1'b0, 1'b0, 1'b0, none);
`endif
    endtask

    task automatic finish_load(input bit ok, input int nwords, input bit lat);
        int n;
        byte_valid = 1'b0;
        n = 0;
        while (!(b_done || b_err) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!(b_done || b_err)) begin
            checks++;
            errors++;
            $display("FAIL end_timeout: no done/err after %0d cycles, required one", n);
        end
        chk("load_done", {31'd0, b_done}, {31'd0, ok});
        chk("load_err", {31'd0, b_err}, {31'd0, !ok});
        chk("cpu_hold", {31'd0, b_hold}, {31'd0, !ok});
        chk("ready_end", {31'd0, b_ready}, 32'd0);
        chk("words_loaded", {23'd0, b_wl}, 32'(nwords));
        chk("words_loaded_le", {23'd0, l_wl}, 32'(nwords));
        chk("done_le", {30'd0, l_done, l_err}, {30'd0, ok, !ok});
        chk("pending_writes", exp_q.size(), 32'd0);
        if (lat && nwords > 0) chk("done_latency", cyc, last_we_cyc + 1);
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_be"}, {b_ready, b_we, b_hold, b_done, b_err, b_wl}, 32'd0);
        chk({name, "_be_bus"}, b_waddr | b_wdata, 32'd0);
        chk({name, "_le"}, {l_ready, l_we, l_hold, l_done, l_err, l_wl}, 32'd0);
        chk({name, "_le_bus"}, l_waddr | l_wdata, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d[$];
        logic [7:0] d1[$];
        int len;

        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_idle("reset");

        d1 = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
        begin_load(16'h0002);
        send_data(d1, 8, 1'b0, -1);
        send_tail(d1, 8, 1'b1);
        finish_load(1'b1, 2, LAT);

        d = '{8'h05, 8'h00, 8'h08, 8'h20};
        begin_load(16'h0001);
        send_data(d, 4, 1'b0, -1);
        send_tail(d, 4, 1'b1);
        finish_load(1'b1, 1, LAT);

        d.delete();
        begin_load(16'h0000);
        send_tail(d, 0, 1'b1);
        finish_load(1'b1, 0, 1'b0);

        begin_load(16'h0101);
        finish_load(1'b0, 0, 1'b0);

        d.delete();
        repeat (1024) d.push_back(8'($urandom));
        begin_load(16'd256);
        send_data(d, 1024, 1'b0, -1);
        send_tail(d, 1024, 1'b1);
        finish_load(1'b1, 256, LAT);

        d.delete();
        repeat (8) d.push_back(8'($urandom));
        begin_load(16'h0002);
        send_data(d, 6, 1'b0, -1);
        reset      = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk);
        chk_idle("mid_reset");
        reset = 1'b0;
        chk("reset_writes", exp_q.size(), 32'd0);
        repeat (4) begin
            byte_valid = 1'($urandom);
            byte_data  = 8'($urandom);
            @(negedge clk);
        end
        byte_valid = 1'b0;
        chk_idle("post_reset");

        begin_load(16'h0002);
        send_data(d1, 8, 1'b1, 5);
        send_tail(d1, 8, 1'b1);
        finish_load(1'b1, 2, LAT);

        repeat (6) begin
            len = $urandom_range(1, 6);
            d.delete();
            repeat (len * 4) d.push_back(8'($urandom));
            begin_load(16'(len));
            send_data(d, len * 4, 1'b1, $urandom_range(0, len * 4 - 1));
            send_tail(d, len * 4, 1'b1);
            finish_load(1'b1, len, LAT);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        d = '{8'h01, 8'h02, 8'h03, 8'h04};
        begin_load(16'h0001);
        send_data(d, 4, 1'b0, -1);
        send_tail(d, 4, 1'b1);
        chk("csum_good_byte", {24'd0, last_csum}, 32'h04);
        finish_load(1'b1, 1, 1'b0);

        begin_load(16'h0001);
        send_data(d, 4, 1'b0, -1);
        send_tail(d, 4, 1'b0);
        finish_load(1'b0, 1, 1'b0);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
